div_nr_seq: RTL
===============

Name: div_nr_seq

Overview:
- Parametrised, multi-cycle, non-restoring integer divider with a start/busy/ready handshake.
- Replaces the fixed 32-bit quotient-only divider in the multdiv unit and runs its own iteration counter.
- Adds per-operation signed/unsigned mode, a remainder output, signed-overflow detection and registered results held until the next start.

Parameters:
- WIDTH, 32, operand/quotient/remainder width in bits (≥4).
- CNT_W, $clog2(WIDTH+1), iteration counter width (derived, not overridden).

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  reset, asynchronous, active-low.
- ctrl_DIV  in  1  start strobe, sampled only in IDLE.
- ctrl_signed  in  1  1 = two's-complement operands, 0 = unsigned; sampled with ctrl_DIV.
- data_operandA  in  WIDTH  dividend; sampled with ctrl_DIV.
- data_operandB  in  WIDTH  divisor; sampled with ctrl_DIV.
- div_result  out  WIDTH  quotient.
- div_remainder  out  WIDTH  remainder.
- div_busy  out  1  operation in progress.
- div_ready  out  1  one-cycle completion pulse.
- div_exception  out  1  divide by zero.
- div_overflow  out  1  signed most-negative / -1.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE; counter=0.
  - All outputs 0; internal A/Q/M registers 0.
  - Reset mid-operation aborts it; no div_ready is produced.
- FSM states: IDLE, ITER, FIX, DONE.
  - IDLE: on ctrl_DIV=1, latch mode, |A| and |B| (signed mode) or raw values (unsigned), and the result-sign flags. Go to ITER, counter=0, div_busy=1.
  - ITER: one non-restoring step per cycle.
    - AQ<<1; A±M chosen by the sign of A; Q[0]=~newA[MSB].
    - A register is WIDTH+1 bits, so unsigned operands with MSB set are handled.
    - counter++; after WIDTH steps go to FIX.
  - FIX: if A<0 then A+=M (remainder restore). Apply signs, register outputs, go to DONE.
    - Quotient is negated when the signs differ (signed mode).
    - Remainder takes the dividend's sign.
  - DONE: div_ready=1 for exactly this cycle, div_busy=0, then IDLE.
- Latency:
  - div_ready is high in the cycle after WIDTH+2 rising edges following the edge that sampled ctrl_DIV.
  - Latency is fixed for all operands, including exceptions.
- ctrl_DIV behaviour:
  - Ignored while div_busy=1 or in DONE.
  - Back-to-back is allowed: ctrl_DIV in the first IDLE cycle after DONE starts a new operation.
- Output holding and update:
  - Outputs (result, remainder, exception, overflow) hold their last values until FIX of the next operation.
  - div_exception and div_overflow change in the same cycle as div_result.
- Arithmetic:
  - Truncation toward zero.
  - Invariant: A = Q·B + R, with |R| < |B|.
- Divide by zero (B=0):
  - div_exception=1, div_result=0, div_remainder=0, div_overflow=0.
  - The iteration still runs but its result is discarded.
- Signed overflow (ctrl_signed=1, A=100…0, B=all-ones):
  - div_overflow=1, div_result=100…0 (wrap), div_remainder=0.
- Unsigned mode: signs are never applied; div_overflow is always 0.

Decomposition:
- Package div_pkg holds:
  - state enum (IDLE/ITER/FIX/DONE);
  - ALU opcode constants ADD=5'b00000, SUB=5'b00001;
  - function is_most_negative(width).
- One sub-module, cond_negate_w (parametrised WIDTH; out = neg ? -in : in).
  - Instantiated for operand abs, quotient sign-fix and remainder sign-fix.
- The adder/subtractor is the existing ALU, widened to WIDTH+1 inside this block.

Test Plan:
- WIDTH=32, signed, A=100, B=7 → after 34 edges: div_ready pulse, result=14, remainder=2, busy low the same cycle, flags 0.
- Signed A=-100, B=7 → result=-14, remainder=-2; A=100, B=-7 → result=-14, remainder=2; A=-100, B=-7 → result=14, remainder=-2.
- Unsigned A=0xFFFF_FFFF, B=2 → result=0x7FFF_FFFF, remainder=1; the same operands in signed mode → result=0, remainder=-1.
- A=5, B=0 → div_exception=1, result=0, remainder=0, ready at the same latency. Signed A=0x8000_0000, B=0xFFFF_FFFF → div_overflow=1, result=0x8000_0000, remainder=0.
- Second ctrl_DIV mid-operation is ignored and the first result is correct. A start in the cycle after div_ready is accepted. Outputs hold between operations.
- Deassert reset_n at iteration 10 → outputs 0 immediately, no ready pulse. The next start completes normally. Repeat the first two scenarios with WIDTH=8 and WIDTH=16, ready after WIDTH+2 edges.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential non-restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } div_state_e;

  localparam logic [4:0] ADD = 5'b00000;
  localparam logic [4:0] SUB = 5'b00001;

  localparam int unsigned MAX_W = 128;

  // True when the low `width` bits of v are 100...0 (two's-complement minimum).
  function automatic logic is_most_negative(input logic [MAX_W-1:0] v, input int unsigned width);
    logic hit;
    hit = 1'b1;
    for (int unsigned i = 0; i < MAX_W; i++) begin
      if (i + 1 == width) hit = hit & v[i];
      else if (i < width) hit = hit & ~v[i];
    end
    return hit;
  endfunction

endpackage

// File: rtl/cond_negate_w.sv
// Conditional two's-complement negation: out = neg ? -in : in.
module cond_negate_w #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] in_i,
  input  logic             neg_i,
  output logic [WIDTH-1:0] out_o
);

  assign out_o = neg_i ? (~in_i + WIDTH'(1)) : in_i;

endmodule

// File: rtl/div_nr_seq.sv
// Multi-cycle non-restoring divider with signed/unsigned mode, remainder,
// divide-by-zero and signed-overflow flags; results held until the next op.
module div_nr_seq
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ctrl_DIV,
  input  logic             ctrl_signed,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] div_result,
  output logic [WIDTH-1:0] div_remainder,
  output logic             div_busy,
  output logic             div_ready,
  output logic             div_exception,
  output logic             div_overflow
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   a_q, a_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             dz_q, dz_d;
  logic             ovfp_q, ovfp_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             exc_q, exc_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             rdy_q, rdy_d;

  logic             neg_a, neg_b;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0]   m_ext, a_sh;
  logic [WIDTH:0]   alu_a, alu_y;
  logic [4:0]       alu_op;
  logic [WIDTH-1:0] r_mag, q_fix, r_fix;

  assign neg_a = ctrl_signed & data_operandA[WIDTH-1];
  assign neg_b = ctrl_signed & data_operandB[WIDTH-1];

  cond_negate_w #(.WIDTH(WIDTH)) u_abs_a (.in_i(data_operandA), .neg_i(neg_a),  .out_o(abs_a));
  cond_negate_w #(.WIDTH(WIDTH)) u_abs_b (.in_i(data_operandB), .neg_i(neg_b),  .out_o(abs_b));
  cond_negate_w #(.WIDTH(WIDTH)) u_q_fix (.in_i(q_q),           .neg_i(qneg_q), .out_o(q_fix));
  cond_negate_w #(.WIDTH(WIDTH)) u_r_fix (.in_i(r_mag),         .neg_i(rneg_q), .out_o(r_fix));

  assign m_ext = {1'b0, m_q};
  assign a_sh  = {a_q[WIDTH-1:0], q_q[WIDTH-1]};

  // Shared WIDTH+1 adder/subtractor: iteration step in ITER, remainder restore in FIX.
  always_comb begin
    if (state_q == S_FIX) begin
      alu_a  = a_q;
      alu_op = ADD;
    end else begin
      alu_a  = a_sh;
      alu_op = a_q[WIDTH] ? ADD : SUB;
    end
    alu_y = (alu_op == SUB) ? (alu_a - m_ext) : (alu_a + m_ext);
  end

  assign r_mag = a_q[WIDTH] ? alu_y[WIDTH-1:0] : a_q[WIDTH-1:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    q_d     = q_q;
    m_d     = m_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    ovfp_d  = ovfp_q;
    res_d   = res_q;
    rem_d   = rem_q;
    exc_d   = exc_q;
    ovf_d   = ovf_q;
    busy_d  = busy_q;
    rdy_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ctrl_DIV) begin
          state_d = S_ITER;
          cnt_d   = '0;
          a_d     = '0;
          q_d     = abs_a;
          m_d     = abs_b;
          qneg_d  = neg_a ^ neg_b;
          rneg_d  = neg_a;
          dz_d    = (data_operandB == '0);
          ovfp_d  = ctrl_signed & is_most_negative(MAX_W'(data_operandA), WIDTH) & (&data_operandB);
          busy_d  = 1'b1;
        end
      end
      S_ITER: begin
        // Once the counter reaches WIDTH this cycle only hands over to FIX.
        if (cnt_q == CNT_W'(WIDTH)) begin
          state_d = S_FIX;
        end else begin
          a_d   = alu_y;
          q_d   = {q_q[WIDTH-2:0], ~alu_y[WIDTH]};
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_FIX: begin
        state_d = S_DONE;
        busy_d  = 1'b0;
        rdy_d   = 1'b1;
        if (dz_q) begin
          res_d = '0;
          rem_d = '0;
          exc_d = 1'b1;
          ovf_d = 1'b0;
        end else begin
          res_d = q_fix;
          rem_d = r_fix;
          exc_d = 1'b0;
          ovf_d = ovfp_q;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      q_q     <= '0;
      m_q     <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      ovfp_q  <= 1'b0;
      res_q   <= '0;
      rem_q   <= '0;
      exc_q   <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      q_q     <= q_d;
      m_q     <= m_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      ovfp_q  <= ovfp_d;
      res_q   <= res_d;
      rem_q   <= rem_d;
      exc_q   <= exc_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      rdy_q   <= rdy_d;
    end
  end

  assign div_result    = res_q;
  assign div_remainder = rem_q;
  assign div_busy      = busy_q;
  assign div_ready     = rdy_q;
  assign div_exception = exc_q;
  assign div_overflow  = ovf_q;

endmodule
